// File: rtl/addsub_nibble_seq.sv
// Nibble-serial WIDTH-bit add/subtract sequencer sharing one 4-bit adder, LSB nibble first.
// Optional macro ADDSUB_SAT_EN clamps the result to the signed limits on overflow.
module addsub_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovfl
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovfl_q, ovfl_d;
    logic             done_q, done_d;

    logic [3:0]       a_nib  [NIB];
    logic [3:0]       bx_nib [NIB];
    logic [3:0]       sum_nib;
    logic             nib_cout;
    logic             msb_cin;
    logic             last_nib;

    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        assign a_nib[gi]  = a_q[4*gi +: 4];
        assign bx_nib[gi] = bx_q[4*gi +: 4];
    end

    // The single shared 4-bit adder.
    always_comb begin
        {nib_cout, sum_nib} = {1'b0, a_nib[cnt_q]} + {1'b0, bx_nib[cnt_q]} + {4'b0000, carry_q};
    end

    assign last_nib = (cnt_q == CW'(NIB - 1));
    // Carry into the top bit is recovered from that bit's sum and its two inputs.
    assign msb_cin  = a_q[WIDTH-1] ^ bx_q[WIDTH-1] ^ sum_nib[3];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        bx_d     = bx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovfl_d   = ovfl_q;
        done_d   = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    bx_d    = op ? ~b : b;
                    carry_d = op;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (cnt_q == CW'(i)) begin
                        result_d[4*i +: 4] = sum_nib;
                    end
                end
                carry_d = nib_cout;
                if (last_nib) begin
                    cout_d  = nib_cout;
                    ovfl_d  = msb_cin ^ nib_cout;
                    state_d = S_DONE;
`ifdef ADDSUB_SAT_EN
                    if (msb_cin ^ nib_cout) begin
                        result_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            bx_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovfl_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            bx_q     <= bx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovfl_q   <= ovfl_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovfl   = ovfl_q;

endmodule
